// File: rtl/rv_pkg.sv
// Shared RV decode constants, bundle layout and ID buffer state encoding.
// Imported by id_dec and id_stage.
package rv_pkg;

  localparam int INS_W  = 32;
  localparam int REG_AW = 5;
  localparam int CSR_AW = 12;
  localparam int ZIMM_W = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RSV  = 3'b100;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LWU  = 3'b110;
  localparam logic [2:0] F3_BAD  = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              mem_rd;
    logic              mem_wr;
    logic [CSR_AW-1:0] csr_addr;
    logic [ZIMM_W-1:0] zimm;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/id_dec.sv
// Combinational RV instruction decoder feeding the ID buffer.
// CSR decode is enabled by defining ID_CSR_EN.
module id_dec
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] shamt;
  logic [31:0] imm32;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        is_ld;
  logic        is_st;
  logic        csr_en;
  logic        zimm_en;
  logic        bad;

  assign op    = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};
  assign shamt = (XLEN == 64) ? {26'b0, ins[25:20]}
                              : {27'b0, ins[24:20]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    csr_en  = 1'b0;
    zimm_en = 1'b0;
    bad     = 1'b0;
    imm32   = '0;
    unique case (1'b1)
      (op == OP_LUI) || (op == OP_AUIPC): begin
        use_rd = 1'b1;
        imm32  = imm_u;
      end
      op == OP_JAL: begin
        use_rd = 1'b1;
        imm32  = imm_j;
      end
      op == OP_JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = imm_i;
        bad     = (f3 != F3_ADD);
      end
      op == OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_b;
        bad     = (f3[2:1] == 2'b01);
      end
      op == OP_LOAD: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_ld   = 1'b1;
        imm32   = imm_i;
        bad     = (f3 == F3_BAD) ||
                  ((XLEN == 32) && (f3 == F3_LD || f3 == F3_LWU));
      end
      op == OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_st   = 1'b1;
        imm32   = imm_s;
        bad     = f3[2] || ((XLEN == 32) && (f3 == F3_LD));
      end
      op == OP_IMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = (f3 == F3_SLL || f3 == F3_SR) ? shamt : imm_i;
      end
      op == OP_REG: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
`ifdef ID_CSR_EN
      op == OP_SYSTEM: begin
        use_rd  = 1'b1;
        csr_en  = 1'b1;
        use_rs1 = ~f3[2];
        zimm_en = f3[2];
        bad     = (f3 == F3_PRIV) || (f3 == F3_RSV);
      end
`endif
      default: bad = 1'b1;
    endcase
  end

  // An illegal word leaves nothing but the raw word and the flag.
  always_comb begin
    dec          = '0;
    dec.ins      = ins;
    dec.illegal  = bad;
    dec.rs1      = (use_rs1 && !bad) ? ins[19:15] : '0;
    dec.rs2      = (use_rs2 && !bad) ? ins[24:20] : '0;
    dec.rd       = (use_rd && !bad) ? ins[11:7] : '0;
    dec.mem_rd   = is_ld && !bad;
    dec.mem_wr   = is_st && !bad;
    dec.csr_addr = (csr_en && !bad) ? ins[31:20] : '0;
    dec.zimm     = (zimm_en && !bad) ? ins[19:15] : '0;
    imm          = bad ? '0 : XLEN'($signed(imm32));
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: input decoder, two-entry main/skid buffer, load-use hold.
// CSR decode is enabled by defining ID_CSR_EN.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       ins_i,
  input  logic [ADDR_W-1:0] ins_addr_i,
  input  logic              flush_i,
  input  logic              ex_load_i,
  input  logic [4:0]        ex_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       ins_o,
  output logic [ADDR_W-1:0] ins_addr_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        reg1_rd_addr_o,
  output logic [4:0]        reg2_rd_addr_o,
  output logic [4:0]        reg_wr_addr_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              mem_rd_flag_o,
  output logic              mem_wr_flag_o,
  output logic [11:0]       csr_rw_addr_o,
  output logic [XLEN-1:0]   csr_zimm_o,
  output logic              illegal_o
);

  buf_state_t        state;
  buf_state_t        state_nx;
  logic              in_ready_q;
  dec_t              dec;
  logic [XLEN-1:0]   dec_imm;
  dec_t              main_q;
  logic [XLEN-1:0]   main_imm_q;
  logic [ADDR_W-1:0] main_addr_q;
  dec_t              skid_q;
  logic [XLEN-1:0]   skid_imm_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic              main_v;
  logic              hazard;
  logic              acc;
  logic              fire;
  logic              load_main;
  logic              load_skid;
  logic              from_skid;

  id_dec #(
    .XLEN (XLEN)
  ) u_dec (
    .ins (ins_i),
    .dec (dec),
    .imm (dec_imm)
  );

  assign main_v = (state != ST_EMPTY);
  assign hazard = ex_load_i && (ex_rd_i != '0) &&
                  (ex_rd_i == main_q.rs1 || ex_rd_i == main_q.rs2);
  assign acc    = in_valid_i && in_ready_q;
  assign fire   = out_valid_o && out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != ST_TWO);
    end
  end

  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (acc) state_nx = ST_ONE;
        ST_ONE: begin
          if (acc && !fire) state_nx = ST_TWO;
          else if (fire && !acc) state_nx = ST_EMPTY;
        end
        ST_TWO: if (fire) state_nx = ST_ONE;
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // In TWO in_ready is low, so only the skid can refill main.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (!flush_i) begin
      unique case (state)
        ST_EMPTY: load_main = acc;
        ST_ONE: begin
          load_main = acc && fire;
          load_skid = acc && !fire;
        end
        ST_TWO: begin
          load_main = fire;
          from_skid = 1'b1;
        end
        default: load_main = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q      <= '0;
      main_imm_q  <= '0;
      main_addr_q <= '0;
    end else if (load_main) begin
      main_q      <= from_skid ? skid_q : dec;
      main_imm_q  <= from_skid ? skid_imm_q : dec_imm;
      main_addr_q <= from_skid ? skid_addr_q : ins_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q      <= '0;
      skid_imm_q  <= '0;
      skid_addr_q <= '0;
    end else if (load_skid) begin
      skid_q      <= dec;
      skid_imm_q  <= dec_imm;
      skid_addr_q <= ins_addr_i;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = main_v && !hazard;
  assign ins_o          = main_q.ins;
  assign ins_addr_o     = main_addr_q;
  assign opcode_o       = main_q.ins[6:0];
  assign funct3_o       = main_q.ins[14:12];
  assign funct7_o       = main_q.ins[31:25];
  assign reg1_rd_addr_o = main_q.rs1;
  assign reg2_rd_addr_o = main_q.rs2;
  assign reg_wr_addr_o  = main_q.rd;
  assign imm_o          = main_imm_q;
  assign mem_rd_flag_o  = main_q.mem_rd;
  assign mem_wr_flag_o  = main_q.mem_wr;
  assign csr_rw_addr_o  = main_q.csr_addr;
  assign csr_zimm_o     = XLEN'(main_q.zimm);
  assign illegal_o      = main_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, hazard hold, skid order, flush, reset.
// Define ID_CSR_EN on both bench and RTL to check the CSR decode.
module tb_id_stage;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  localparam logic [31:0] I_ADDI_M1 = 32'hFFF00093;
  localparam logic [31:0] I_LW      = 32'h00012283;
  localparam logic [31:0] I_ADD     = 32'h00128333;
  localparam logic [31:0] I_A1      = 32'h00100093;
  localparam logic [31:0] I_A2      = 32'h00200113;
  localparam logic [31:0] I_A3      = 32'h00300193;
  localparam logic [31:0] I_SW      = 32'h0020A423;
  localparam logic [31:0] I_BEQ     = 32'hFE208EE3;
  localparam logic [31:0] I_SRAI    = 32'h4030D093;
  localparam logic [31:0] I_CSRRWI  = 32'h3002D1F3;
  localparam logic [31:0] I_ECALL   = 32'h00000073;
  localparam logic [31:0] I_BADOP   = 32'h0000007F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [31:0]       ins_i = '0;
  logic [ADDR_W-1:0] ins_addr_i = '0;
  logic              flush_i = 1'b0;
  logic              ex_load_i = 1'b0;
  logic [4:0]        ex_rd_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [31:0]       ins_o;
  logic [ADDR_W-1:0] ins_addr_o;
  logic [6:0]        opcode_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [4:0]        reg1_rd_addr_o;
  logic [4:0]        reg2_rd_addr_o;
  logic [4:0]        reg_wr_addr_o;
  logic [XLEN-1:0]   imm_o;
  logic              mem_rd_flag_o;
  logic              mem_wr_flag_o;
  logic [11:0]       csr_rw_addr_o;
  logic [XLEN-1:0]   csr_zimm_o;
  logic              illegal_o;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .ins_i          (ins_i),
    .ins_addr_i     (ins_addr_i),
    .flush_i        (flush_i),
    .ex_load_i      (ex_load_i),
    .ex_rd_i        (ex_rd_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .ins_o          (ins_o),
    .ins_addr_o     (ins_addr_o),
    .opcode_o       (opcode_o),
    .funct3_o       (funct3_o),
    .funct7_o       (funct7_o),
    .reg1_rd_addr_o (reg1_rd_addr_o),
    .reg2_rd_addr_o (reg2_rd_addr_o),
    .reg_wr_addr_o  (reg_wr_addr_o),
    .imm_o          (imm_o),
    .mem_rd_flag_o  (mem_rd_flag_o),
    .mem_wr_flag_o  (mem_wr_flag_o),
    .csr_rw_addr_o  (csr_rw_addr_o),
    .csr_zimm_o     (csr_zimm_o),
    .illegal_o      (illegal_o)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    in_valid_i = 1'b1;
    ins_i      = w;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    step();
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_ins", ins_o, 0);
    check("rst_imm", imm_o, 0);
    check("rst_rd", reg_wr_addr_o, 0);
    rst = 1'b0;

    out_ready_i = 1'b1;
    ins_addr_i  = 32'h100;
    issue(I_ADDI_M1);
    ex_load_i = 1'b1;
    ex_rd_i   = 5'd0;
    #1;
    check("addi_valid", out_valid_o, 1);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_rd", reg_wr_addr_o, 1);
    check("addi_rs1", reg1_rd_addr_o, 0);
    check("addi_ill", illegal_o, 0);
    check("addi_op", opcode_o, 7'h13);
    check("addi_pc", ins_addr_o, 32'h100);
    ex_load_i = 1'b0;
    step();
    check("addi_drain", out_valid_o, 0);

    issue(I_LW);
    check("lw_mrd", mem_rd_flag_o, 1);
    check("lw_mwr", mem_wr_flag_o, 0);
    check("lw_rs1", reg1_rd_addr_o, 2);
    check("lw_rd", reg_wr_addr_o, 5);
    issue(I_ADD);
    ex_load_i = 1'b1;
    ex_rd_i   = 5'd5;
    #1;
    check("hz_hold", out_valid_o, 0);
    check("hz_rs2", reg2_rd_addr_o, 1);
    step();
    ex_load_i = 1'b0;
    #1;
    check("hz_release", out_valid_o, 1);
    check("hz_ins", ins_o, I_ADD);
    check("hz_rd", reg_wr_addr_o, 6);
    check("hz_mrd", mem_rd_flag_o, 0);
    step();
    check("hz_drain", out_valid_o, 0);

    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    ins_i       = I_A1;
    step();
    check("bp1_ready", in_ready_o, 1);
    check("bp1_ins", ins_o, I_A1);
    ins_i = I_A2;
    step();
    check("bp2_ready", in_ready_o, 0);
    check("bp2_ins", ins_o, I_A1);
    ins_i = I_A3;
    step();
    check("bp3_ready", in_ready_o, 0);
    check("bp3_hold", ins_o, I_A1);
    check("bp3_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    step();
    check("bp_out2", ins_o, I_A2);
    check("bp_out2v", out_valid_o, 1);
    step();
    in_valid_i = 1'b0;
    check("bp_out3", ins_o, I_A3);
    check("bp_imm3", imm_o, 3);
    step();
    check("bp_empty", out_valid_o, 0);

    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    ins_i       = I_A1;
    step();
    ins_i = I_A2;
    step();
    check("fl_two", in_ready_o, 0);
    ins_i   = I_A3;
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("fl_valid", out_valid_o, 0);
    check("fl_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    step();
    check("fl_gone", out_valid_o, 0);
    out_ready_i = 1'b0;
    issue(I_A1);
    in_valid_i = 1'b1;
    ins_i      = I_A2;
    flush_i    = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("fl1_valid", out_valid_o, 0);
    step();
    check("fl1_gone", out_valid_o, 0);

    out_ready_i = 1'b1;
    issue(I_SW);
    check("sw_mwr", mem_wr_flag_o, 1);
    check("sw_mrd", mem_rd_flag_o, 0);
    check("sw_rd", reg_wr_addr_o, 0);
    check("sw_rs1", reg1_rd_addr_o, 1);
    check("sw_rs2", reg2_rd_addr_o, 2);
    check("sw_imm", imm_o, 8);
    issue(I_BEQ);
    check("beq_imm", imm_o, 32'hFFFFFFFC);
    check("beq_rd", reg_wr_addr_o, 0);
    issue(I_SRAI);
    check("srai_imm", imm_o, 3);
    check("srai_f7", funct7_o, 7'h20);
    issue(I_CSRRWI);
`ifdef ID_CSR_EN
    check("csr_addr", csr_rw_addr_o, 12'h300);
    check("csr_zimm", csr_zimm_o, 5);
    check("csr_rd", reg_wr_addr_o, 3);
    check("csr_rs1", reg1_rd_addr_o, 0);
    check("csr_ill", illegal_o, 0);
`else
    check("csr_ill", illegal_o, 1);
    check("csr_addr", csr_rw_addr_o, 0);
    check("csr_zimm", csr_zimm_o, 0);
    check("csr_rd", reg_wr_addr_o, 0);
`endif
    issue(I_ECALL);
    check("ecall_ill", illegal_o, 1);
    issue(I_BADOP);
    check("bad_ill", illegal_o, 1);
    check("bad_imm", imm_o, 0);
    check("bad_rd", reg_wr_addr_o, 0);
    check("bad_rs1", reg1_rd_addr_o, 0);
    check("bad_rs2", reg2_rd_addr_o, 0);
    check("bad_valid", out_valid_o, 1);
    step();

    out_ready_i = 1'b0;
    issue(I_A1);
    issue(I_A2);
    check("mr_pre", in_ready_o, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", out_valid_o, 0);
    check("mr_ready", in_ready_o, 1);
    check("mr_ins", ins_o, 0);
    check("mr_rd", reg_wr_addr_o, 0);
    #1;
    rst = 1'b0;
    step();
    check("mr_after", out_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined, parametrised instruction-decode stage that sits between the IF stage and the EX stage. It accepts fetched instructions over a valid/ready handshake and decodes them into opcode, function fields, register addresses, an XLEN-wide immediate, memory flags and CSR fields. The decoded bundle is held in a two-entry output buffer (main plus skid). A load-use interlock holds back a decoded instruction while the EX stage still owes it load data.

## Interface
- `XLEN`, 32: data and immediate width; legal values 32 or 64.
- `ADDR_W`, 32: instruction address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid_i`  in  1  IF presents an instruction.
- `in_ready_o`  out  1  stage can accept; registered.
- `ins_i`  in  32  instruction word.
- `ins_addr_i`  in  ADDR_W  instruction address.
- `flush_i`  in  1  discard all buffered and incoming instructions.
- `ex_load_i`  in  1  EX currently holds a load.
- `ex_rd_i`  in  5  destination register of that load.
- `out_valid_o`  out  1  decoded bundle valid for EX.
- `out_ready_i`  in  1  EX accepts the bundle.
- `ins_o` out 32, `ins_addr_o` out ADDR_W: instruction word and address passed through.
- `opcode_o` out 7, `funct3_o` out 3, `funct7_o` out 7: decoded function fields.
- `reg1_rd_addr_o`, `reg2_rd_addr_o`, `reg_wr_addr_o`  out  5 each: source and destination register addresses.
- `imm_o`  out  XLEN  sign-extended immediate.
- `mem_rd_flag_o` out 1, `mem_wr_flag_o` out 1: load instruction; store instruction.
- `csr_rw_addr_o` out 12, `csr_zimm_o` out XLEN: CSR address and zero-extended uimm.
- `illegal_o`  out  1  unrecognised opcode or funct3.

## Operation
- Decode rules:
  - I-ALU, JALR and LOAD immediates are `ins[31:20]`, sign-extended to XLEN. SLTIU is sign-extended as well.
  - For SLLI, SRLI and SRAI the immediate is the zero-extended shamt: `ins[24:20]` when XLEN=32, `ins[25:20]` when XLEN=64.
  - LUI and AUIPC: `{ins[31:12], 12'b0}`, sign-extended.
  - JAL, BRANCH and STORE use the standard RV encodings, sign-extended.
  - Unused register addresses are driven to 0. BRANCH and STORE drive `reg_wr_addr_o` = 0.
  - `mem_rd_flag_o` is set for LOAD only. `mem_wr_flag_o` is set for STORE only.
  - Any unknown opcode sets `illegal_o`=1 and drives all addresses, `imm_o` and flags to 0.
- Buffer states:
  - EMPTY: main and skid both empty.
  - ONE: main valid.
  - TWO: main and skid valid.
- Definitions: accept = `in_valid_i & in_ready_o`; fire = `out_valid_o & out_ready_i`.
- State transitions:
  - EMPTY → ONE on accept.
  - ONE: accept without fire → TWO; fire without accept → EMPTY; accept with fire → ONE (main replaced).
  - TWO: on fire, skid moves to main → ONE. No accept is possible in TWO.
- `in_ready_o` = 1 in EMPTY and ONE, and 0 in TWO. It is registered from the next state.
- Hazard = `ex_load_i & (ex_rd_i != 0) & (ex_rd_i == reg1_rd_addr_o | ex_rd_i == reg2_rd_addr_o)` for the bundle in main.
- `out_valid_o` = main valid & ~hazard. The bundle is held unchanged until the hazard clears.
- Flush: the next state is EMPTY and any same-cycle input is discarded. Flush takes priority over accept and fire.
- Skid/main order is strictly FIFO, so decode order is preserved.

## Timing
- Reset: all outputs are 0 except `in_ready_o`, which is 1. State is EMPTY.
- Reset asserted mid-operation drops both entries immediately (asynchronously).
- Latency: 1 cycle from accept to `out_valid_o` (absent hazard).
- Throughput: 1 instruction/cycle with `out_ready_i` held high.
- Outputs are stable while `out_valid_o` = 1 and `out_ready_i` = 0.
- The hazard path is combinational from `ex_*_i` to `out_valid_o`. No other input reaches an output combinationally.

## Configuration
- `ID_CSR_EN` defined:
  - Opcode 1110011 decodes as follows.
  - CSRRW/S/C: rs1 read; `csr_rw_addr_o` = `ins[31:20]`.
  - CSRRWI/SI/CI: reg1 = 0; `csr_zimm_o` = zero-extended `ins[19:15]`.
  - funct3 000 or 100: `illegal_o`=1.
- `ID_CSR_EN` undefined:
  - Opcode 1110011 is illegal.
  - `csr_rw_addr_o` and `csr_zimm_o` are tied to 0.

## Structure
- Shared package `rv_pkg` holds:
  - opcode and funct3 constants;
  - the decoded-bundle field widths;
  - the buffer state encoding.
- Sub-module `id_dec`: purely combinational decoder, instantiated once at the input. The decoded bundle is stored in the buffer, not the raw instruction.
- `id_stage` top contains the two-entry buffer, the state machine and the hazard logic.

## Test plan
- addi x1,x0,-1 (0xFFF00093) with out_ready_i=1 → next cycle: `out_valid_o`=1, imm=0xFFFFFFFF, rd=1, rs1=0, `illegal_o`=0.
- lw x5,0(x2) (0x00012283) → `mem_rd_flag_o`=1, `mem_wr_flag_o`=0, rs1=2, rd=5. Then add x6,x5,x1 (0x00128333) with ex_load_i=1, ex_rd_i=5 for one cycle → `out_valid_o`=0 for that cycle, then 1 with bundle unchanged.
- out_ready_i=0, three instructions offered back-to-back → two accepted, `in_ready_o`=0 from cycle 2. Raise out_ready_i → all three emerge in order, one per cycle.
- flush_i asserted in state TWO together with in_valid_i → next cycle: `out_valid_o`=0, `in_ready_o`=1, the same-cycle instruction never appears.
- csrrwi x3,0x300,5 (0x3002D1F3) with `ID_CSR_EN` → csr_rw_addr=0x300, zimm=5, rd=3, reg1=0. Without `ID_CSR_EN` → `illegal_o`=1.
- 0x0000007F → `illegal_o`=1, all addresses and imm 0. Reset asserted mid-stream → outputs 0 and `in_ready_o`=1 immediately.
